// File: rtl/ahb_sram_pkg.sv
// ahb_sram_pkg: shared AHB-Lite encodings, FSM state type, default slave
// constants and the byte-lane helper used by the SRAM slave.
package ahb_sram_pkg;

  // HTRANS encodings
  localparam logic [1:0] HTRANS_IDLE    = 2'b00;
  localparam logic [1:0] HTRANS_BUSY    = 2'b01;
  localparam logic [1:0] HTRANS_NON_SEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ     = 2'b11;

  // HSIZE encodings
  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  // HRESP encodings
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Default read-only window and wait-state configuration
  localparam logic [31:0] DEF_RO_START    = 32'h0000_0000;
  localparam logic [31:0] DEF_RO_END      = 32'h0000_0003;
  localparam logic [31:0] DEF_WAIT_ADDR   = 32'h0000_0005;
  localparam int          DEF_WAIT_CYCLES = 2;

  // Response FSM states
  typedef enum logic [1:0] {
    ST_OKAY = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_e;

  // Little-endian byte lanes touched by a transfer of 2**size bytes starting
  // at byte offset 'offset' within a bus word (up to 8 lanes).
  function automatic logic [7:0] byte_lanes(input logic [2:0] offset,
                                            input logic [2:0] size);
    logic [7:0]  lanes;
    int unsigned first;
    int unsigned last;
    first = 32'(offset);
    last  = first + (32'd1 << size) - 32'd1;
    for (int unsigned b = 0; b < 8; b++) begin
      lanes[b] = (b >= first) && (b <= last);
    end
    return lanes;
  endfunction

endpackage

// File: rtl/ahb_sram_if.sv
// ahb_sram_if: AHB-Lite slave-port signal bundle. The master side also
// supplies HREADY, standing in for the bus-level ready from the mux.
interface ahb_sram_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [1:0]            HTRANS;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADYOUT;
  logic                  HRESP;

  modport slave (
    input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );

  modport master (
    output HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

endinterface

// File: rtl/ahb_sram_array.sv
// ahb_sram_array: DEPTH x DATA_WIDTH word storage with per-byte write enable
// and asynchronous read. Contents are deliberately not reset.
module ahb_sram_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_BITS  = 10
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_BITS-1:0]    addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Commit the enabled byte lanes of the addressed word
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be[b]) begin
          mem_r[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem_r[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite SRAM slave with byte/halfword/word writes, a
// read-only window, a wait-state word and two-cycle ERROR responses.
// Build option: define AHB_SRAM_RO_PROTECT_EN to make writes into the
// RO_START..RO_END window return ERROR; otherwise the window is plain RAM.
module ahb_sram_slave
  import ahb_sram_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DATA_WIDTH  = 32,
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] RO_START    = DEF_RO_START,
  parameter logic [31:0] RO_END      = DEF_RO_END,
  parameter logic [31:0] WAIT_ADDR   = DEF_WAIT_ADDR,
  parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic HCLK,
  input  logic HRESETn,
  ahb_sram_if.slave bus
);

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int BYTE_BITS = $clog2(BYTES);
  localparam int MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  localparam logic [ADDR_WIDTH:0]   DEPTH_WORDS = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] WAIT_WORD   = ADDR_WIDTH'(WAIT_ADDR >> BYTE_BITS);
  localparam logic [ADDR_WIDTH:0]   RO_START_X  = (ADDR_WIDTH+1)'(RO_START);
  localparam logic [ADDR_WIDTH:0]   RO_END_X    = (ADDR_WIDTH+1)'(RO_END);
  localparam logic [CNT_W-1:0]      WAIT_LOAD   = CNT_W'(WAIT_CYCLES);

`ifdef AHB_SRAM_RO_PROTECT_EN
  localparam logic RO_PROTECT = 1'b1;
`else
  localparam logic RO_PROTECT = 1'b0;
`endif

  // Address-phase decode
  logic                  accept_s;
  logic                  sample_s;
  logic [2:0]            offset_s;
  logic [ADDR_WIDTH-1:0] word_s;
  logic [ADDR_WIDTH:0]   first_s;
  logic [ADDR_WIDTH:0]   last_s;
  logic                  size_err_s;
  logic                  align_err_s;
  logic                  range_err_s;
  logic                  ro_err_s;
  logic                  err_s;
  logic                  wait_s;

  // FSM
  state_e                state_r;
  state_e                state_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cnt_s;
  logic                  hreadyout_r;
  logic                  hresp_r;

  // Data phase
  logic                  dp_valid_r;
  logic [ADDR_WIDTH-1:0] haddr_r;
  logic                  hwrite_r;
  logic [2:0]            hsize_r;
  logic                  mem_we_s;
  logic [BYTES-1:0]      mem_be_s;
  logic [MEM_AW-1:0]     mem_addr_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic [DATA_WIDTH-1:0] hrdata_s;

  // HBURST carries no information for a single-port SRAM
  logic                  unused_bits_s;
  assign unused_bits_s = ^bus.HBURST;

  // Classify the presented address phase as error, wait or plain access
  always_comb begin
    accept_s    = (state_r == ST_OKAY) || (state_r == ST_ERR2);
    sample_s    = accept_s && bus.HSEL && bus.HREADY &&
                  ((bus.HTRANS == HTRANS_NON_SEQ) || (bus.HTRANS == HTRANS_SEQ));
    offset_s    = 3'(bus.HADDR[BYTE_BITS-1:0]);
    word_s      = bus.HADDR >> BYTE_BITS;
    size_err_s  = bus.HSIZE > 3'(BYTE_BITS);
    align_err_s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      align_err_s = align_err_s | (offset_s[i] & (3'(i) < bus.HSIZE));
    end
    range_err_s = {1'b0, word_s} >= DEPTH_WORDS;
    // One extra bit keeps the last-byte computation from wrapping
    first_s     = {1'b0, bus.HADDR};
    last_s      = first_s + ((ADDR_WIDTH+1)'(1) << bus.HSIZE) - (ADDR_WIDTH+1)'(1);
    ro_err_s    = RO_PROTECT && bus.HWRITE && (first_s <= RO_END_X) && (last_s >= RO_START_X);
    err_s       = size_err_s || align_err_s || range_err_s || ro_err_s;
    wait_s      = (WAIT_CYCLES != 0) && (word_s == WAIT_WORD) && !err_s;
  end

  // Next-state and wait-counter logic of the response FSM
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_OKAY, ST_ERR2: begin
        if (sample_s && err_s) begin
          state_s = ST_ERR1;
          cnt_s   = '0;
        end else if (sample_s && wait_s) begin
          state_s = ST_WAIT;
          cnt_s   = WAIT_LOAD;
        end else begin
          state_s = ST_OKAY;
          cnt_s   = '0;
        end
      end
      ST_WAIT: begin
        if (cnt_r <= CNT_W'(1)) begin
          state_s = ST_OKAY;
          cnt_s   = '0;
        end else begin
          state_s = ST_WAIT;
          cnt_s   = cnt_r - CNT_W'(1);
        end
      end
      ST_ERR1: begin
        state_s = ST_ERR2;
        cnt_s   = '0;
      end
      default: begin
        state_s = ST_OKAY;
        cnt_s   = '0;
      end
    endcase
  end

  // State, counter and registered HREADYOUT/HRESP derived from the next state
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r     <= ST_OKAY;
      cnt_r       <= '0;
      hreadyout_r <= 1'b1;
      hresp_r     <= HRESP_OKAY;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      hreadyout_r <= (state_s == ST_OKAY) || (state_s == ST_ERR2);
      hresp_r     <= ((state_s == ST_ERR1) || (state_s == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    end
  end

  // Capture the address phase; hold it while the data phase is stretched
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid_r <= 1'b0;
      haddr_r    <= '0;
      hwrite_r   <= 1'b0;
      hsize_r    <= HSIZE_BYTE;
    end else if (accept_s) begin
      dp_valid_r <= sample_s && !err_s;
      if (sample_s) begin
        haddr_r  <= bus.HADDR;
        hwrite_r <= bus.HWRITE;
        hsize_r  <= bus.HSIZE;
      end
    end
  end

  // Data-phase memory control and read-data gating
  always_comb begin
    mem_addr_s = MEM_AW'(haddr_r >> BYTE_BITS);
    mem_be_s   = BYTES'(byte_lanes(3'(haddr_r[BYTE_BITS-1:0]), hsize_r));
    // A write lands on the edge that ends its data phase (HREADYOUT high)
    mem_we_s   = (state_r == ST_OKAY) && dp_valid_r && hwrite_r;
    if ((state_r == ST_OKAY) && dp_valid_r && !hwrite_r) begin
      hrdata_s = rd_word_s;
    end else begin
      hrdata_s = '0;
    end
  end

  ahb_sram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_BITS  (MEM_AW)
  ) u_array (
    .clk   (HCLK),
    .we    (mem_we_s),
    .be    (mem_be_s),
    .addr  (mem_addr_s),
    .wdata (bus.HWDATA),
    .rdata (rd_word_s)
  );

  assign bus.HREADYOUT = hreadyout_r;
  assign bus.HRESP     = hresp_r;
  assign bus.HRDATA    = hrdata_s;

endmodule
